channel_isi_tx_prl: RTL and testbench

// - Transmit-side channel model feeding the parallel DFE receiver: maps 2-bit PAM4 symbols to signed levels.
// - Convolves them with the loaded pulse response (same m*2^y word format and load_mem/location/mem_data load interface as the receiver).
// - Emits one saturated SIGNAL_RESOLUTION-bit channel sample per accepted symbol.
// - Sits between the symbol source and DFE_prl.signal_in/signal_in_valid in the on-chip-memory sim system.

---
 rtl/channel_isi_tx_prl.sv | 198 +++++++++++++++++++
 tb/tb_channel_isi_tx_prl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_isi_tx_prl.sv
`default_nettype none
//==============================================================================
// Module   : channel_isi_tx_prl
// Desc     : PAM4 transmit channel model. Convolves symbol levels with a loaded
//            pulse response and emits one saturated sample per accepted symbol.
//            Optional additive LFSR noise: define CHANNEL_NOISE_EN.
// Revision : 1.0
//==============================================================================
module channel_isi_tx_prl #(
   parameter int PULSE_RESPONSE_LENGTH = 5,
   parameter int SIGNAL_RESOLUTION     = 8,
   parameter int SYMBOL_SEPERATION     = 56
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [1:0]                   symbol_in,
   input  logic                         symbol_in_valid,
   output logic [SIGNAL_RESOLUTION-1:0] signal_out,
   output logic                         signal_out_valid,
   input  logic                         load_mem,
   input  logic [7:0]                   location,
   input  logic [63:0]                  mem_data,
   output logic                         done_wait,
   output logic                         sat_flag
);

   localparam int c_PRL    = PULSE_RESPONSE_LENGTH;
   localparam int c_SR     = SIGNAL_RESOLUTION;
   localparam int c_LVL_W  = $clog2(3 * SYMBOL_SEPERATION / 2 + 1) + 1;
   localparam int c_PROD_W = c_LVL_W + 16;
   localparam int c_SUM_W  = c_SR + 16 + $clog2(c_PRL);
   localparam int c_OUT_W  = c_SUM_W + 1;
   localparam int c_MAX_I  = (2 ** (c_SR - 1)) - 1;

   localparam logic signed [c_LVL_W-1:0] c_LVL3   = c_LVL_W'(3 * SYMBOL_SEPERATION / 2);
   localparam logic signed [c_LVL_W-1:0] c_LVL1   = c_LVL_W'(SYMBOL_SEPERATION / 2);
   localparam logic signed [c_OUT_W-1:0] c_SAT_HI = c_OUT_W'(c_MAX_I);
   localparam logic signed [c_OUT_W-1:0] c_SAT_LO = c_OUT_W'(-c_MAX_I - 1);

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic                        w_accept;
   logic                        w_wr_en;
   logic [7:0]                  r_wr_cnt;
   logic signed [15:0]          r_m    [c_PRL];
   logic [15:0]                 r_y    [c_PRL];
   logic signed [c_LVL_W-1:0]   r_hist [c_PRL-1];
   logic signed [c_LVL_W-1:0]   w_lvl;
   logic signed [c_PROD_W-1:0]  w_prod [c_PRL];
   logic signed [c_PROD_W-1:0]  r_prod [c_PRL];
   logic [4:0]                  r_shift;
   logic                        r_v1;
   logic signed [c_SUM_W-1:0]   w_sum;
   logic signed [c_SUM_W-1:0]   w_shifted;
   logic signed [c_OUT_W-1:0]   w_out_full;
   logic [c_SR-1:0]             w_out;
   logic                        w_clip;
   logic                        w_unused_bits;

   assign w_wr_en = load_mem && (location < 8'(c_PRL));

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_accept = symbol_in_valid && done_wait && !load_mem;
            if (done_wait) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            w_accept = symbol_in_valid && !load_mem;
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= ST_LOAD;
         r_wr_cnt  <= 8'd0;
         done_wait <= 1'b0;
         for (int k = 0; k < c_PRL; k++) begin
            r_m[k] <= '0;
            r_y[k] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         if (w_wr_en) r_wr_cnt <= r_wr_cnt + 8'd1;
         if (r_wr_cnt >= 8'(c_PRL)) done_wait <= 1'b1;
         // Write lands in the addressed tap this very cycle
         for (int k = 0; k < c_PRL; k++) begin
            if (w_wr_en && (location == 8'(k))) begin
               r_m[k] <= mem_data[31:16];
               r_y[k] <= mem_data[15:0];
            end
         end
      end
   end

   always_comb begin
      case (symbol_in)
         2'b00:   w_lvl = -c_LVL3;
         2'b01:   w_lvl = -c_LVL1;
         2'b10:   w_lvl = c_LVL1;
         default: w_lvl = c_LVL3;
      endcase
   end

   for (genvar k = 0; k < c_PRL; k++) begin : g_tap
      if (k == 0) begin : g_cursor
         assign w_prod[k] = c_PROD_W'(w_lvl) * c_PROD_W'(r_m[k]);
      end else begin : g_post
         assign w_prod[k] = c_PROD_W'(r_hist[k-1]) * c_PROD_W'(r_m[k]);
      end
   end

`ifdef CHANNEL_NOISE_EN
   logic [15:0]       r_lfsr;
   logic signed [2:0] r_noise;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_lfsr  <= 16'hACE1;
         r_noise <= '0;
      end else if (w_accept) begin
         r_noise <= r_lfsr[2:0];
         r_lfsr  <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      end
   end
`endif

   // Stage 1: history shift and per-tap products; y0 is captured so later tap
   // writes cannot disturb a sample already in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_v1    <= 1'b0;
         r_shift <= 5'd0;
         for (int k = 0; k < c_PRL; k++) r_prod[k] <= '0;
         for (int k = 0; k < c_PRL - 1; k++) r_hist[k] <= '0;
      end else begin
         r_v1 <= w_accept;
         if (w_accept) begin
            r_hist[0] <= w_lvl;
            for (int k = 1; k < c_PRL - 1; k++) r_hist[k] <= r_hist[k-1];
            for (int k = 0; k < c_PRL; k++) r_prod[k] <= w_prod[k];
            r_shift <= r_y[0][4:0];
         end
      end
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < c_PRL; k++) w_sum = w_sum + c_SUM_W'(r_prod[k]);
      w_shifted = w_sum >>> r_shift;
`ifdef CHANNEL_NOISE_EN
      w_out_full = c_OUT_W'(w_shifted) + c_OUT_W'(r_noise);
`else
      w_out_full = c_OUT_W'(w_shifted);
`endif
      w_out  = w_out_full[c_SR-1:0];
      w_clip = 1'b0;
      if (w_out_full > c_SAT_HI) begin
         w_out  = {1'b0, {(c_SR-1){1'b1}}};
         w_clip = 1'b1;
      end else if (w_out_full < c_SAT_LO) begin
         w_out  = {1'b1, {(c_SR-1){1'b0}}};
         w_clip = 1'b1;
      end
   end

   // Stage 2: registered sample, valid pulse and sticky saturation flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         signal_out       <= '0;
         signal_out_valid <= 1'b0;
         sat_flag         <= 1'b0;
      end else begin
         signal_out_valid <= r_v1;
         if (r_v1) begin
            signal_out <= w_out;
            if (w_clip) sat_flag <= 1'b1;
         end
      end
   end

   // Upper data word and the post-cursor shift fields carry no function here
   always_comb begin
      w_unused_bits = (^mem_data[63:32]) ^ (^r_y[0][15:5]);
      for (int k = 1; k < c_PRL; k++) w_unused_bits = w_unused_bits ^ (^r_y[k]);
   end

endmodule
`default_nettype wire

// File: tb/tb_channel_isi_tx_prl.sv
`default_nettype none
//==============================================================================
// Module   : tb_channel_isi_tx_prl
// Desc     : Self-checking bench for channel_isi_tx_prl (vector table, directed
//            sequences, randomized stream against a behavioural channel model).
// Revision : 1.0
//==============================================================================
module tb_channel_isi_tx_prl;

   localparam int PRL = 5;
   localparam int SR  = 8;
   localparam int SEP = 56;
   localparam int OUT_HI = (2 ** (SR - 1)) - 1;
   localparam int OUT_LO = -(2 ** (SR - 1));

   logic          clk = 1'b0;
   logic          rstn;
   logic [1:0]    symbol_in;
   logic          symbol_in_valid;
   logic [SR-1:0] signal_out;
   logic          signal_out_valid;
   logic          load_mem;
   logic [7:0]    location;
   logic [63:0]   mem_data;
   logic          done_wait;
   logic          sat_flag;

   always #5 clk = ~clk;

   channel_isi_tx_prl #(
      .PULSE_RESPONSE_LENGTH (PRL),
      .SIGNAL_RESOLUTION     (SR),
      .SYMBOL_SEPERATION     (SEP)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .symbol_in        (symbol_in),
      .symbol_in_valid  (symbol_in_valid),
      .signal_out       (signal_out),
      .signal_out_valid (signal_out_valid),
      .load_mem         (load_mem),
      .location         (location),
      .mem_data         (mem_data),
      .done_wait        (done_wait),
      .sat_flag         (sat_flag)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // ---------------- behavioural channel model ----------------
   typedef struct {
      longint due;
      int     val;
      bit     clip;
   } exp_t;

   exp_t        expq[$];
   int          m_tap  [PRL];
   int          m_hist [PRL];
   int          m_y0;
   int          m_cnt;
   bit          m_done;
   bit          m_sat;
   longint      cyc = 0;
   logic [15:0] m_lfsr;

   function automatic int pam_level(input logic [1:0] code);
      return ((2 * int'(code)) - 3) * SEP / 2;
   endfunction

   function automatic longint floor_div_pow2(input longint num, input int sh);
      longint d;
      longint q;
      d = longint'(1) << sh;
      q = num / d;
      if ((num % d != 0) && (num < 0)) q = q - 1;
      return q;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < PRL; k++) begin
         m_tap[k]  = 0;
         m_hist[k] = 0;
      end
      m_y0   = 0;
      m_cnt  = 0;
      m_done = 1'b0;
      m_sat  = 1'b0;
      m_lfsr = 16'hACE1;
      expq.delete();
   endtask

   task automatic accept_symbol(input logic [1:0] code);
      longint sum;
      longint v;
      exp_t   e;
      for (int k = PRL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = pam_level(code);
      sum = 0;
      for (int k = 0; k < PRL; k++) sum += longint'(m_hist[k]) * longint'(m_tap[k]);
      v = floor_div_pow2(sum, m_y0);
`ifdef CHANNEL_NOISE_EN
      v += longint'($signed(m_lfsr[2:0]));
      m_lfsr = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
`endif
      e.clip = (v > OUT_HI) || (v < OUT_LO);
      e.val  = (v > OUT_HI) ? OUT_HI : (v < OUT_LO) ? OUT_LO : int'(v);
      e.due  = cyc + 1;
      expq.push_back(e);
   endtask

   always @(posedge clk) begin
      cyc++;
      if (!rstn) begin
         model_clear();
      end else begin
         if (symbol_in_valid && m_done && !load_mem) accept_symbol(symbol_in);
         if (m_cnt >= PRL) m_done = 1'b1;
         if (load_mem && (location < PRL)) begin
            m_tap[location] = int'($signed(mem_data[31:16]));
            if (location == 0) m_y0 = int'(mem_data[4:0]);
            m_cnt = (m_cnt + 1) % 256;
         end
      end
   end

   exp_t mon_e;
   bit   mon_ev;

   always @(negedge clk) begin
      if (!rstn) begin
         check("rst_valid", signal_out_valid, 0);
         check("rst_done", done_wait, 0);
      end else begin
         while ((expq.size() > 0) && (expq[0].due < cyc)) begin
            void'(expq.pop_front());
            fail("sample_missed");
         end
         mon_ev = (expq.size() > 0) && (expq[0].due == cyc);
         check("out_valid", signal_out_valid, mon_ev);
         if (mon_ev) begin
            mon_e = expq.pop_front();
            if (mon_e.clip) m_sat = 1'b1;
            check("sample", $signed(signal_out), mon_e.val);
         end
         check("done_wait", done_wait, m_done);
         check("sat_flag", sat_flag, m_sat);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      symbol_in       = 2'd0;
      symbol_in_valid = 1'b0;
      load_mem        = 1'b0;
      location        = 8'd0;
      mem_data        = 64'd0;
   endtask

   task automatic do_reset();
      idle();
      rstn = 1'b0;
      model_clear();
      repeat (2) cycle();
      rstn = 1'b1;
   endtask

   task automatic write_tap(input int loc, input int m, input int y);
      load_mem = 1'b1;
      location = 8'(loc);
      mem_data = {32'hDEAD_BEEF, 16'(m), 16'(y)};
      cycle();
      load_mem = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done_wait && (n < 8)) begin
         cycle();
         n++;
      end
      if (!done_wait) fail(name);
   endtask

   task automatic load_taps(input int m0, input int m1, input int m2, input int m3,
                            input int m4, input int y0);
      write_tap(0, m0, y0);
      write_tap(1, m1, 0);
      write_tap(2, m2, 0);
      write_tap(3, m3, 0);
      write_tap(4, m4, 0);
      wait_done("load_timeout");
   endtask

   function automatic int rand_m();
      return int'($urandom_range(0, 400)) - 200;
   endfunction

   typedef struct {
      logic [1:0] sym;
      logic       vld;
      logic       exp_v;
      int         exp_out;
   } vec_t;

   vec_t tbl [16];

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         symbol_in       = tbl[i].sym;
         symbol_in_valid = tbl[i].vld;
         load_mem        = 1'b0;
         @(negedge clk);
         check($sformatf("row%0d_valid", i), signal_out_valid, tbl[i].exp_v);
         if (tbl[i].exp_v) check($sformatf("row%0d_out", i), $signed(signal_out), tbl[i].exp_out);
         cycle();
      end
      idle();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      // Row i checks the output produced by the symbol of row i-2
      tbl[0]  = '{2'd3, 1'b1, 1'b0, 0};
      tbl[1]  = '{2'd0, 1'b0, 1'b0, 0};
      tbl[2]  = '{2'd0, 1'b0, 1'b1, 84};
      tbl[3]  = '{2'd0, 1'b0, 1'b0, 0};
      tbl[4]  = '{2'd1, 1'b0, 1'b0, 0};
      tbl[5]  = '{2'd2, 1'b1, 1'b0, 0};
      tbl[6]  = '{2'd2, 1'b1, 1'b0, 0};
      tbl[7]  = '{2'd2, 1'b1, 1'b1, 49};
      tbl[8]  = '{2'd0, 1'b0, 1'b1, 24};
      tbl[9]  = '{2'd0, 1'b0, 1'b1, 31};
      tbl[10] = '{2'd0, 1'b0, 1'b0, 0};
      tbl[11] = '{2'd3, 1'b1, 1'b0, 0};
      tbl[12] = '{2'd0, 1'b1, 1'b0, 0};
      tbl[13] = '{2'd0, 1'b0, 1'b1, 127};
      tbl[14] = '{2'd0, 1'b0, 1'b1, -128};
      tbl[15] = '{2'd0, 1'b0, 1'b0, 0};

      idle();
      rstn = 1'b0;
      model_clear();
      do_reset();
      @(negedge clk);
      check("reset_out", signal_out, 0);
      check("reset_valid", signal_out_valid, 0);
      check("reset_done", done_wait, 0);
      check("reset_sat", sat_flag, 0);
      cycle();

`ifndef CHANNEL_NOISE_EN
      // Drops leave history untouched; stream 11,10,10,10 with y0=6
      load_taps(64, 16, -8, 0, 0, 6);
      run_rows(0, 10);
      @(negedge clk);
      check("no_sat_a", sat_flag, 0);
      cycle();

      do_reset();
      load_taps(127, 0, 0, 0, 0, 0);
      run_rows(11, 15);
      @(negedge clk);
      check("sat_sticky", sat_flag, 1);
      cycle();

      // Out-of-range location neither writes nor counts
      do_reset();
      for (int k = 0; k < 4; k++) write_tap(k, 10, 0);
      write_tap(7, 99, 0);
      repeat (3) cycle();
      check("loc7_done", done_wait, 0);
      for (int i = 0; i < 4; i++) begin
         symbol_in       = 2'd3;
         symbol_in_valid = 1'b1;
         @(negedge clk);
         check("nodone_drop", signal_out_valid, 0);
         cycle();
      end
      idle();
      write_tap(4, 10, 0);
      wait_done("loc7_reload_timeout");
      check("loc4_done", done_wait, 1);

      // Symbol coinciding with a tap write is dropped
      symbol_in       = 2'd3;
      symbol_in_valid = 1'b1;
      load_mem        = 1'b1;
      location        = 8'd1;
      mem_data        = {32'h0, 16'(10), 16'h0};
      cycle();
      idle();
      repeat (3) begin
         @(negedge clk);
         check("load_drop", signal_out_valid, 0);
         cycle();
      end

      // Reset with a sample in flight
      do_reset();
      load_taps(64, 16, -8, 0, 0, 6);
      symbol_in       = 2'd3;
      symbol_in_valid = 1'b1;
      cycle();
      idle();
      rstn = 1'b0;
      model_clear();
      repeat (3) begin
         @(negedge clk);
         check("midrst_valid", signal_out_valid, 0);
         check("midrst_done", done_wait, 0);
         cycle();
      end
      rstn = 1'b1;
      load_taps(64, 16, -8, 0, 0, 6);
      symbol_in       = 2'd2;
      symbol_in_valid = 1'b1;
      cycle();
      idle();
      @(negedge clk);
      check("post_rst_lat", signal_out_valid, 0);
      cycle();
      @(negedge clk);
      check("post_rst_valid", signal_out_valid, 1);
      check("post_rst_hist0", $signed(signal_out), 28);
      cycle();
`else
      load_taps(64, 0, 0, 0, 0, 6);
      repeat (8) begin
         symbol_in       = 2'd2;
         symbol_in_valid = 1'b1;
         cycle();
      end
      idle();
      repeat (3) cycle();
`endif

      // Randomized stream, including tap rewrites and one reset mid-run
      do_reset();
      load_taps(rand_m(), rand_m(), rand_m(), rand_m(), rand_m(), int'($urandom_range(4, 8)));
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            do_reset();
            load_taps(rand_m(), rand_m(), rand_m(), rand_m(), rand_m(), int'($urandom_range(3, 9)));
         end
         symbol_in       = 2'($urandom_range(0, 3));
         symbol_in_valid = ($urandom_range(0, 9) < 7);
         load_mem        = ($urandom_range(0, 99) < 5);
         location        = 8'($urandom_range(0, 6));
         mem_data        = {$urandom, 16'(rand_m()),
                            16'(($urandom_range(0, 2047) << 5) | $urandom_range(3, 9))};
         cycle();
      end
      idle();
      repeat (4) cycle();
      check("queue_drained", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
